// File: rtl/pc_unit_param.sv
// pc_unit_param: parametrised fetch program counter for the RISC-V core.
// After reset the PC is held at RESET_VECTOR for BOOT_CYCLES edges (BOOT), and
// then advances every edge (RUN) with priority trap > stall > sequential/redirect.
// A redirect to a misaligned target is diverted to the trap vector. It raises a
// one-cycle MisalignFlt pulse and records the target in FaultAddr.
// Optional feature macro: PC_STATS_EN builds the saturating RedirCnt/StallCnt
// counters. When the macro is undefined, both counter outputs are tied to zero.
module pc_unit_param #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_CYCLES  = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  PCTarget,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic [XLEN-1:0]  TrapVector,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCPlus4,
  output logic             PCValid,
  output logic             MisalignFlt,
  output logic [XLEN-1:0]  FaultAddr,
  output logic [CNT_W-1:0] RedirCnt,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int              BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [BW-1:0]   BOOT_ONE  = BW'(1);
  localparam logic [XLEN-1:0] PC_INC    = XLEN'(4);
  localparam logic [XLEN-1:0] ALU_MASK  = ~(XLEN'(1));
  localparam logic [XLEN-1:0] TRAP_MASK = ~(XLEN'(3));

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BW-1:0]   r_boot_cnt;
  logic [BW-1:0]   w_boot_cnt_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_misalign;
  logic            w_misalign;
  logic [XLEN-1:0] r_fault;
  logic [XLEN-1:0] w_fault_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_trap_pc;

  // The JALR target always has bit 0 cleared. The trap handler is always word aligned.
  assign w_pc_plus4 = r_pc + PC_INC;
  assign w_tgt      = (PCSrc == 2'b01) ? PCTarget : (ALUResult & ALU_MASK);
  assign w_trap_pc  = TrapVector & TRAP_MASK;

  // Boot/run sequencing: count BOOT_CYCLES edges, then stay in RUN until reset.
  always_comb begin
    w_state_next    = r_state;
    w_boot_cnt_next = r_boot_cnt;
    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_next = S_RUN;
        end else begin
          w_boot_cnt_next = r_boot_cnt + BOOT_ONE;
        end
      end
      S_RUN: begin
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next    = S_BOOT;
        w_boot_cnt_next = '0;
      end
    endcase
  end

  // Next-PC selection with trap > stall > sequential/redirect priority; misalign detection.
  always_comb begin
    w_pc_next    = r_pc;
    w_misalign   = 1'b0;
    w_fault_next = r_fault;
    if (r_state == S_RUN) begin
      if (PCSrc == 2'b11) begin
        w_pc_next = w_trap_pc;
      end else if (Stall) begin
        w_pc_next = r_pc;
      end else if (PCSrc == 2'b00) begin
        w_pc_next = w_pc_plus4;
      end else if (w_tgt[1:0] != 2'b00) begin
        w_pc_next    = w_trap_pc;
        w_misalign   = 1'b1;
        w_fault_next = w_tgt;
      end else begin
        w_pc_next = w_tgt;
      end
    end else begin
      w_pc_next = RESET_VECTOR;
    end
  end

  // State, PC and fault registers; reset clears everything at once.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
      r_fault    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_boot_cnt <= w_boot_cnt_next;
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign;
      r_fault    <= w_fault_next;
    end
  end

  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign PCValid     = (r_state == S_RUN);
  assign MisalignFlt = r_misalign;
  assign FaultAddr   = r_fault;

`ifdef PC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_redirect;
  logic             w_stall_evt;
  logic [CNT_W-1:0] r_redir_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Classify the current RUN edge: redirect load (01/10/11) or stalled hold.
  always_comb begin
    w_redirect  = 1'b0;
    w_stall_evt = 1'b0;
    if (r_state == S_RUN) begin
      w_redirect  = (PCSrc == 2'b11) || (!Stall && (PCSrc != 2'b00));
      w_stall_evt = Stall && (PCSrc != 2'b11);
    end else begin
      w_redirect  = 1'b0;
      w_stall_evt = 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_redir_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_redirect && (r_redir_cnt != '1)) begin
        r_redir_cnt <= r_redir_cnt + CNT_ONE;
      end
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign RedirCnt = r_redir_cnt;
  assign StallCnt = r_stall_cnt;
`else
  assign RedirCnt = '0;
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_pc_unit_param.sv
// Scoreboard bench for pc_unit_param: stimulus pushes hand-computed expectations,
// a monitor pops and compares them after each rising edge.
module tb_pc_unit_param;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = 32'h0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] TrapVector = 32'h0;
  logic [31:0] PC, PCPlus4, FaultAddr, RedirCnt, StallCnt;
  logic        PCValid, MisalignFlt;
  logic [31:0] PC2, PCPlus42, FaultAddr2;
  logic        PCValid2, MisalignFlt2;
  logic [1:0]  RedirCnt2, StallCnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] fa;
    logic [31:0] redir;
    logic [31:0] stl;
    logic [31:0] redir2;
    logic [31:0] stl2;
  } exp_t;

  exp_t sb[$];
  int   exp_redir = 0;
  int   exp_stall = 0;
  logic run_q = 1'b0;
  int   step_id = 0;

  pc_unit_param #(.XLEN(32), .RESET_VECTOR(32'h0), .BOOT_CYCLES(2), .CNT_W(32)) u_dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .ALUResult(ALUResult), .TrapVector(TrapVector), .PC(PC), .PCPlus4(PCPlus4),
    .PCValid(PCValid), .MisalignFlt(MisalignFlt), .FaultAddr(FaultAddr),
    .RedirCnt(RedirCnt), .StallCnt(StallCnt)
  );

  pc_unit_param #(.XLEN(32), .RESET_VECTOR(32'h0), .BOOT_CYCLES(2), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .ALUResult(ALUResult), .TrapVector(TrapVector), .PC(PC2), .PCPlus4(PCPlus42),
    .PCValid(PCValid2), .MisalignFlt(MisalignFlt2), .FaultAddr(FaultAddr2),
    .RedirCnt(RedirCnt2), .StallCnt(StallCnt2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] alu, input logic [31:0] trap,
                      input logic [31:0] exp_pc, input logic exp_valid,
                      input logic exp_mis, input logic [31:0] exp_fa);
    exp_t e;
    Stall = st; PCSrc = src; PCTarget = tgt; ALUResult = alu; TrapVector = trap;
    if (run_q && ((src == 2'b11) || (!st && (src != 2'b00)))) exp_redir++;
    if (run_q && st && (src != 2'b11)) exp_stall++;
    run_q = exp_valid;
    e.id = step_id; e.pc = exp_pc; e.valid = exp_valid; e.mis = exp_mis; e.fa = exp_fa;
`ifdef PC_STATS_EN
    e.redir = exp_redir; e.stl = exp_stall;
    e.redir2 = sat3(exp_redir); e.stl2 = sat3(exp_stall);
`else
    e.redir = 0; e.stl = 0; e.redir2 = 0; e.stl2 = 0;
`endif
    sb.push_back(e);
    step_id++;
    @(negedge CLK);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"}, PC, 32'h0);
    chk({tag, ".pcplus4"}, PCPlus4, 32'h4);
    chk({tag, ".valid"}, {31'h0, PCValid}, 32'h0);
    chk({tag, ".mis"}, {31'h0, MisalignFlt}, 32'h0);
    chk({tag, ".fa"}, FaultAddr, 32'h0);
    chk({tag, ".redir"}, RedirCnt, 32'h0);
    chk({tag, ".stall"}, StallCnt, 32'h0);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest expectation.
  always begin
    exp_t e;
    @(posedge CLK);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("s%0d.pc", e.id), PC, e.pc);
      chk($sformatf("s%0d.pcplus4", e.id), PCPlus4, e.pc + 32'd4);
      chk($sformatf("s%0d.valid", e.id), {31'h0, PCValid}, {31'h0, e.valid});
      chk($sformatf("s%0d.mis", e.id), {31'h0, MisalignFlt}, {31'h0, e.mis});
      chk($sformatf("s%0d.fa", e.id), FaultAddr, e.fa);
      chk($sformatf("s%0d.redir", e.id), RedirCnt, e.redir);
      chk($sformatf("s%0d.stall", e.id), StallCnt, e.stl);
      chk($sformatf("s%0d.redir_w2", e.id), {30'h0, RedirCnt2}, e.redir2);
      chk($sformatf("s%0d.stall_w2", e.id), {30'h0, StallCnt2}, e.stl2);
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk_reset_state("reset");
    // BOOT: two edges, PCSrc=11 must be ignored
    step(1'b0, 2'b11, 32'h0, 32'h0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 2'b11, 32'h0, 32'h0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0);
    // Sequential fetch
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h8, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'hC, 1'b1, 1'b0, 32'h0);
    // Branch / JALR redirects
    step(1'b0, 2'b01, 32'h100, 32'h0, 32'h0, 32'h100, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b01, 32'h200, 32'h0, 32'h0, 32'h200, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b10, 32'h0, 32'h305, 32'h0, 32'h304, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b01, 32'h100, 32'h0, 32'h0, 32'h100, 1'b1, 1'b0, 32'h0);
    // Misaligned branch target -> trap vector, one-cycle pulse
    step(1'b0, 2'b01, 32'h202, 32'h0, 32'h80, 32'h80, 1'b1, 1'b1, 32'h202);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h80, 32'h84, 1'b1, 1'b0, 32'h202);
    // Misaligned JALR target (bit 0 cleared first), trap vector low bits forced to 0
    step(1'b0, 2'b10, 32'h0, 32'h107, 32'h81, 32'h80, 1'b1, 1'b1, 32'h106);
    step(1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 32'h106);
    // Stalls hold PC, including a stalled misaligned redirect
    step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 32'h106);
    step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 32'h106);
    step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 32'h106);
    step(1'b1, 2'b01, 32'h202, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 32'h106);
    // Trap wins over stall
    step(1'b1, 2'b11, 32'h0, 32'h0, 32'h83, 32'h80, 1'b1, 1'b0, 32'h106);
    // Wrap-around at the top of the address space
    step(1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h106);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h106);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h106);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h106);
    // Reset asserted mid-cycle: outputs return immediately
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_state("midreset");
    exp_redir = 0; exp_stall = 0; run_q = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge CLK);
    chk("sb_drain", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
